// File: rtl/inst_loader.sv
`default_nettype none
// ============================================================================
//  Module   : inst_loader
//  Purpose  : Boot-time owner of the instruction memory byte port. Receives a
//             length-prefixed program image from the UART, writes it into
//             instruction memory while the core is stalled, sends one ack
//             byte to the host, then hands the memory port to core fetch.
//  Revision : 1.0 - initial release
// ============================================================================
module inst_loader #(
  parameter int         ADDR_W   = 12,
  parameter logic [7:0] ACK_BYTE = 8'hAA
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_stall,
  output logic              core_run,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  output logic              err
);

  // Controller states
  localparam logic [2:0] c_HDR  = 3'd0;
  localparam logic [2:0] c_LOAD = 3'd1;
  localparam logic [2:0] c_ACK  = 3'd2;
  localparam logic [2:0] c_RUN  = 3'd3;
  localparam logic [2:0] c_ERR  = 3'd4;

  // Memory capacity in bytes, one bit wider than len so the compare is exact
  localparam logic [32:0] c_CAP = 33'd1 << ADDR_W;

  logic [2:0]        r_state;
  logic [1:0]        r_hdr_cnt;
  logic [ADDR_W-1:0] r_wptr;
  logic [31:0]       r_len;

  logic              w_accept;
  logic [31:0]       w_len_next;
  logic              w_len_bad;
  logic              w_last;

  // Header bytes arrive MSB first, so each accepted byte shifts in at the bottom
  assign w_accept   = rx_valid & rx_ready;
  assign w_len_next = {r_len[23:0], rx_data};
  // Length must be word aligned and fit in memory; compared at full width
  assign w_len_bad  = (w_len_next[1:0] != 2'b00) || ({1'b0, w_len_next} > c_CAP);
  // Byte being written is the final one of the image
  assign w_last     = ({{(32-ADDR_W){1'b0}}, r_wptr} == (r_len - 32'd1));

  // Controller state, header parsing and write pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= c_HDR;
      r_hdr_cnt <= 2'd0;
      r_wptr    <= '0;
      r_len     <= 32'd0;
    end else begin
      case (r_state)
        c_HDR: begin
          if (w_accept) begin
            r_len     <= w_len_next;
            r_hdr_cnt <= r_hdr_cnt + 2'd1;
            if (r_hdr_cnt == 2'd3) begin
              if (w_len_next == 32'd0) begin
                r_state <= c_ACK;
              end else if (w_len_bad) begin
                r_state <= c_ERR;
              end else begin
                r_state <= c_LOAD;
                r_wptr  <= '0;
              end
            end
          end
        end
        c_LOAD: begin
          if (w_accept) begin
            r_wptr <= r_wptr + 1'b1;
            if (w_last) begin
              r_state <= c_ACK;
            end
          end
        end
        c_ACK: begin
          if (tx_ready) begin
            r_state <= c_RUN;
          end
        end
        default: begin
          r_state <= r_state;
        end
      endcase
    end
  end

  // Output decode; memory port goes to fetch only once the core is running
  always_comb begin
    rx_ready    = (r_state == c_HDR) || (r_state == c_LOAD);
    tx_valid    = (r_state == c_ACK);
    tx_data     = ACK_BYTE;
    core_run    = (r_state == c_RUN);
    fetch_stall = (r_state != c_RUN);
    err         = (r_state == c_ERR);
    mem_we      = (r_state == c_LOAD) && rx_valid;
    mem_wdata   = rx_data;
    mem_addr    = (r_state == c_RUN) ? fetch_addr : r_wptr;
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_inst_loader
//  Purpose  : Self-checking bench for inst_loader using directed scenarios
//             and randomized loads against a transaction-level model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_inst_loader;

  localparam int ADDR_W = 12;
  localparam int DEPTH  = 1 << ADDR_W;

  localparam int P_HDR  = 0;
  localparam int P_LOAD = 1;
  localparam int P_ACK  = 2;
  localparam int P_RUN  = 3;
  localparam int P_ERR  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              tx_valid;
  logic [7:0]        tx_data;
  logic              tx_ready;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_stall;
  logic              core_run;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic              err;

  inst_loader #(.ADDR_W(ADDR_W), .ACK_BYTE(8'hAA)) dut (
    .clk(clk), .rst(rst),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .fetch_addr(fetch_addr), .fetch_stall(fetch_stall), .core_run(core_run),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .err(err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Transaction-level model: phase, collected header bytes, length, bytes written
  int           m_phase;
  logic [7:0]   m_hdr[$];
  longint       m_len;
  int           m_wcount;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_status(input string tag);
    chk({tag, ":rx_ready"},    32'(rx_ready),    32'(m_phase == P_HDR || m_phase == P_LOAD));
    chk({tag, ":tx_valid"},    32'(tx_valid),    32'(m_phase == P_ACK));
    chk({tag, ":core_run"},    32'(core_run),    32'(m_phase == P_RUN));
    chk({tag, ":fetch_stall"}, 32'(fetch_stall), 32'(m_phase != P_RUN));
    chk({tag, ":err"},         32'(err),         32'(m_phase == P_ERR));
    chk({tag, ":mem_we_idle"}, 32'(mem_we),      32'd0);
    if (m_phase != P_RUN)
      chk({tag, ":mem_addr"}, 32'(mem_addr), 32'(m_wcount % DEPTH));
  endtask

  task automatic model_reset();
    m_phase  = P_HDR;
    m_hdr.delete();
    m_len    = 0;
    m_wcount = 0;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    #1;
    chk_status("reset");
  endtask

  // Offer one byte after `gap` idle cycles; checks the write strobe and
  // advances the model by the loader's acceptance rules
  task automatic send(input logic [7:0] b, input int gap);
    repeat (gap) begin
      @(posedge clk); #1;
      chk_status("gap");
    end
    rx_valid   = 1'b1;
    rx_data    = b;
    fetch_addr = ADDR_W'($urandom);
    #1;
    chk("mem_we", 32'(mem_we), 32'(m_phase == P_LOAD));
    if (m_phase == P_LOAD) begin
      chk("mem_addr_wr", 32'(mem_addr), 32'(m_wcount % DEPTH));
      chk("mem_wdata", 32'(mem_wdata), 32'(b));
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
    case (m_phase)
      P_HDR: begin
        m_hdr.push_back(b);
        if (m_hdr.size() == 4) begin
          m_len = (longint'(m_hdr[0]) * 16777216) + (longint'(m_hdr[1]) * 65536)
                + (longint'(m_hdr[2]) * 256) + longint'(m_hdr[3]);
          m_hdr.delete();
          if (m_len == 0)                         m_phase = P_ACK;
          else if (m_len % 4 != 0 || m_len > DEPTH) m_phase = P_ERR;
          else begin
            m_phase  = P_LOAD;
            m_wcount = 0;
          end
        end
      end
      P_LOAD: begin
        m_wcount++;
        if (m_wcount == m_len) m_phase = P_ACK;
      end
      default: ;
    endcase
    #1;
    chk_status("after_byte");
  endtask

  task automatic send_header(input logic [31:0] len, input int maxgap);
    for (int i = 3; i >= 0; i--)
      send(8'(len >> (8 * i)), $urandom_range(0, maxgap));
  endtask

  // Hold the ack for `hold` cycles (with stray rx bytes), then complete it
  task automatic ack_handshake(input int hold);
    tx_ready = 1'b0;
    repeat (hold) send(8'($urandom), 0);
    tx_ready = 1'b1;
    #1;
    chk("ack_valid", 32'(tx_valid), 32'd1);
    chk("ack_data", 32'(tx_data), 32'hAA);
    @(posedge clk); #1;
    tx_ready = 1'b0;
    m_phase  = P_RUN;
    #1;
    chk_status("run");
  endtask

  // In RUN the memory address follows fetch_addr combinationally, no writes
  task automatic run_checks(input int n);
    logic [ADDR_W-1:0] fa;
    repeat (n) begin
      fa         = ADDR_W'($urandom);
      fetch_addr = fa;
      rx_valid   = 1'($urandom);
      rx_data    = 8'($urandom);
      #1;
      chk("run_mem_addr", 32'(mem_addr), 32'(fa));
      chk("run_mem_we", 32'(mem_we), 32'd0);
      @(posedge clk); #1;
      rx_valid = 1'b0;
      #1;
      chk_status("run_hold");
    end
  endtask

  initial begin
    logic [7:0]  prog[8];
    logic [31:0] len;
    int          kind;
    int          guard;

    prog       = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
    rst        = 1'b0;
    rx_valid   = 1'b0;
    rx_data    = 8'h00;
    tx_ready   = 1'b0;
    fetch_addr = '0;

    // Reset state
    do_reset();

    // Normal 8-byte load, ack back-pressure, handoff
    send_header(32'd8, 0);
    for (int i = 0; i < 8; i++) send(prog[i], 0);
    ack_handshake(5);
    fetch_addr = 12'h004;
    #1;
    chk("handoff_addr", 32'(mem_addr), 32'h004);
    run_checks(6);

    // Zero length goes straight to ack
    do_reset();
    send_header(32'd0, 2);
    ack_handshake(1);
    run_checks(2);

    // Unaligned length
    do_reset();
    send_header(32'd6, 1);
    repeat (3) send(8'($urandom), 1);

    // Oversize length
    do_reset();
    send_header(32'h0000_1004, 0);
    repeat (2) send(8'($urandom), 0);

    // Full-capacity image
    do_reset();
    send_header(32'h0000_1000, 0);
    for (int i = 0; i < DEPTH; i++) send(8'($urandom), $urandom_range(0, 1));
    ack_handshake(2);
    run_checks(2);

    // Reset in the middle of a load restarts header parsing
    do_reset();
    send_header(32'd8, 0);
    repeat (3) send(8'($urandom), 0);
    do_reset();
    send_header(32'd12, 1);
    for (int i = 0; i < 12; i++) send(8'($urandom), $urandom_range(0, 2));
    ack_handshake(0);
    run_checks(3);

    // Randomized images
    repeat (12) begin
      do_reset();
      kind = $urandom_range(0, 3);
      case (kind)
        0:       len = 32'(4 * $urandom_range(1, 16));
        1:       len = $urandom;
        2:       len = 32'd4100;
        default: len = 32'($urandom_range(1, 64));
      endcase
      send_header(len, 3);
      guard = 0;
      while (m_phase == P_LOAD && guard < 5000) begin
        send(8'($urandom), $urandom_range(0, 2));
        guard++;
      end
      if (m_phase == P_ACK) begin
        ack_handshake($urandom_range(0, 3));
        run_checks(2);
      end else begin
        repeat (2) send(8'($urandom), 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
